// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage in front of a 1-cycle-latency
// synchronous instruction memory.
//
// The unit owns the PC and drives the memory address. It pairs each returned
// memory word with the PC that requested it, and presents a (valid, pc, instr)
// packet to decode. Decode can stall the packet and execute can redirect it.
// Fetch halts when the memory returns EOF_WORD.
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   Defined   : a redirect to a non-word-aligned target halts fetch and sets
//               misalign. misalign stays set until reset or until a later
//               aligned redirect.
//   Undefined : redirect_pc[1:0] is forced to 2'b00 and misalign is always 0.
//
// Ports:
//   clk            in   1   clock, rising edge
//   rst            in   1   asynchronous active-high reset
//   imem_addr      out  32  byte address to instruction memory (combinational)
//   imem_instr     in   32  memory word for the address of the previous cycle
//   id_stall       in   1   decode cannot accept the packet this cycle
//   redirect_valid in   1   taken branch / jump / flush from execute
//   redirect_pc    in   32  redirect target
//   if_valid       out  1   fetch packet valid
//   if_pc          out  32  PC of if_instr
//   if_instr       out  32  instruction (pass-through of imem_instr)
//   halted         out  1   fetch stopped
//   misalign       out  1   misaligned redirect trap flag
//   fetch_count    out  32  packets accepted by decode (wraps)
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] EOF_WORD = 32'hDEAD_BEEF,
  parameter logic [31:0] PC_STEP  = 32'h0000_0004
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        id_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        halted,
  output logic        misalign,
  output logic [31:0] fetch_count
);

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [31:0] pc_r, pc_nxt_s;
  logic [31:0] pc_d1_r, pc_d1_nxt_s;
  logic        resp_valid_r, resp_valid_nxt_s;
  logic        misalign_r, misalign_nxt_s;
  logic [31:0] fetch_count_r;
  logic [31:0] redir_pc_s;
  logic        trap_s;
  logic        eof_s;
  logic        accept_s;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign redir_pc_s = redirect_pc;
  assign trap_s     = redirect_valid & (redirect_pc[1:0] != 2'b00);
`else
  // Low address bits are dropped, so a misaligned target fetches its word.
  logic unused_redir_lsb_s;
  assign redir_pc_s         = {redirect_pc[31:2], 2'b00};
  assign trap_s             = 1'b0;
  assign unused_redir_lsb_s = ^redirect_pc[1:0];
`endif

  // EOF only counts when the memory word really belongs to an in-flight request.
  assign eof_s = resp_valid_r & (imem_instr == EOF_WORD);

  assign if_pc       = pc_d1_r;
  assign if_instr    = imem_instr;
  assign if_valid    = resp_valid_r & (state_r == RUN) & ~eof_s & ~redirect_valid;
  assign halted      = (state_r == HALT);
  assign misalign    = misalign_r;
  assign fetch_count = fetch_count_r;
  assign accept_s    = if_valid & ~id_stall;

  // Address mux: redirect first. Halt or stall replays pc_d1 so the memory
  // output, and with it the presented packet, stays stable.
  always_comb begin
    imem_addr = pc_r;
    if (redirect_valid) begin
      imem_addr = redir_pc_s;
    end else if ((state_r == HALT) || id_stall) begin
      imem_addr = pc_d1_r;
    end else begin
      imem_addr = pc_r;
    end
  end

  // Next-state logic: redirect beats EOF and stall, in both RUN and HALT.
  always_comb begin
    state_nxt_s      = state_r;
    pc_nxt_s         = pc_r;
    pc_d1_nxt_s      = pc_d1_r;
    resp_valid_nxt_s = resp_valid_r;
    misalign_nxt_s   = misalign_r;
    if (redirect_valid) begin
      if (trap_s) begin
        state_nxt_s      = HALT;
        misalign_nxt_s   = 1'b1;
        pc_d1_nxt_s      = redirect_pc;
        resp_valid_nxt_s = 1'b0;
      end else begin
        // Target is requested this cycle, so its data arrives next cycle.
        state_nxt_s      = RUN;
        misalign_nxt_s   = 1'b0;
        pc_nxt_s         = redir_pc_s + PC_STEP;
        pc_d1_nxt_s      = redir_pc_s;
        resp_valid_nxt_s = 1'b1;
      end
    end else begin
      case (state_r)
        RUN: begin
          if (eof_s) begin
            state_nxt_s      = HALT;
            resp_valid_nxt_s = 1'b0;
          end else if (id_stall) begin
            state_nxt_s = RUN;
          end else begin
            pc_nxt_s         = pc_r + PC_STEP;
            pc_d1_nxt_s      = pc_r;
            resp_valid_nxt_s = 1'b1;
          end
        end
        HALT: begin
          state_nxt_s = HALT;
        end
        default: begin
          state_nxt_s      = HALT;
          resp_valid_nxt_s = 1'b0;
        end
      endcase
    end
  end

  // Fetch state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= RUN;
      pc_r         <= RESET_PC;
      pc_d1_r      <= RESET_PC;
      resp_valid_r <= 1'b0;
      misalign_r   <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      pc_r         <= pc_nxt_s;
      pc_d1_r      <= pc_d1_nxt_s;
      resp_valid_r <= resp_valid_nxt_s;
      misalign_r   <= misalign_nxt_s;
    end
  end

  // Count of packets accepted by decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count_r <= 32'h0000_0000;
    end else if (accept_s) begin
      fetch_count_r <= fetch_count_r + 32'h0000_0001;
    end else begin
      fetch_count_r <= fetch_count_r;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a directed table, a mid-run reset,
// and a randomized run against a transaction-level reference model.
module tb_fetch_unit;

  localparam logic [31:0] EOF = 32'hDEAD_BEEF;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        id_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        halted;
  logic        misalign;
  logic [31:0] fetch_count;

  int checks;
  int failures;
  logic [31:0] eof_addr;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .id_stall       (id_stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .halted         (halted),
    .misalign       (misalign),
    .fetch_count    (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The memory holds word == address, except for the end-of-program marker.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == eof_addr) ? EOF : a;
  endfunction

  // Synchronous memory with one cycle of read latency.
  always @(posedge clk) imem_instr <= mem_word(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        v;
    logic [31:0] pc;
    logic [31:0] addr;
    logic        halt;
    logic        mis;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[21];

  task automatic setv(input int i, input logic s, input logic r, input logic [31:0] rp,
                      input logic v, input logic [31:0] pc, input logic [31:0] ad,
                      input logic h, input logic m, input logic [31:0] c);
    vecs[i].stall = s; vecs[i].redir = r; vecs[i].rpc = rp;
    vecs[i].v = v; vecs[i].pc = pc; vecs[i].addr = ad;
    vecs[i].halt = h; vecs[i].mis = m; vecs[i].cnt = c;
  endtask

  // Reference model state: next address to request, address whose data is
  // arriving, whether that data counts, halt flag, and accepted count.
  logic [31:0] m_next, m_fly, m_cnt;
  bit          m_fly_ok, m_halt;

  task automatic model_reset();
    m_next = 32'h0; m_fly = 32'h0; m_cnt = 32'h0; m_fly_ok = 1'b0; m_halt = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    logic        e_valid;
    logic [31:0] e_addr;
    checks = 0; failures = 0;
    eof_addr = 32'h0000_01FC;
    rst = 1'b1; id_stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;

    // Directed table: one row per cycle, starting at reset release.
    setv(0,  1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 32'd0);
    setv(1,  1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   32'h4,   1'b0, 1'b0, 32'd0);
    setv(2,  1'b0, 1'b0, 32'h0,   1'b1, 32'h4,   32'h8,   1'b0, 1'b0, 32'd1);
    setv(3,  1'b1, 1'b0, 32'h0,   1'b1, 32'h8,   32'h8,   1'b0, 1'b0, 32'd2);
    setv(4,  1'b1, 1'b0, 32'h0,   1'b1, 32'h8,   32'h8,   1'b0, 1'b0, 32'd2);
    setv(5,  1'b1, 1'b0, 32'h0,   1'b1, 32'h8,   32'h8,   1'b0, 1'b0, 32'd2);
    setv(6,  1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   32'hC,   1'b0, 1'b0, 32'd2);
    setv(7,  1'b0, 1'b0, 32'h0,   1'b1, 32'hC,   32'h10,  1'b0, 1'b0, 32'd3);
    setv(8,  1'b0, 1'b1, 32'h40,  1'b0, 32'h10,  32'h40,  1'b0, 1'b0, 32'd4);
    setv(9,  1'b0, 1'b0, 32'h0,   1'b1, 32'h40,  32'h44,  1'b0, 1'b0, 32'd4);
    setv(10, 1'b1, 1'b1, 32'h80,  1'b0, 32'h44,  32'h80,  1'b0, 1'b0, 32'd5);
    setv(11, 1'b0, 1'b1, 32'h1F8, 1'b0, 32'h80,  32'h1F8, 1'b0, 1'b0, 32'd5);
    setv(12, 1'b0, 1'b0, 32'h0,   1'b1, 32'h1F8, 32'h1FC, 1'b0, 1'b0, 32'd5);
    setv(13, 1'b0, 1'b0, 32'h0,   1'b0, 32'h1FC, 32'h200, 1'b0, 1'b0, 32'd6);
    setv(14, 1'b0, 1'b0, 32'h0,   1'b0, 32'h1FC, 32'h1FC, 1'b1, 1'b0, 32'd6);
    setv(15, 1'b0, 1'b1, 32'h0,   1'b0, 32'h1FC, 32'h0,   1'b1, 1'b0, 32'd6);
    setv(16, 1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   32'h4,   1'b0, 1'b0, 32'd6);
`ifdef FETCH_MISALIGN_TRAP_EN
    setv(17, 1'b0, 1'b1, 32'h42,  1'b0, 32'h0,   32'h42,  1'b0, 1'b0, 32'd7);
    setv(18, 1'b0, 1'b0, 32'h0,   1'b0, 32'h42,  32'h42,  1'b1, 1'b1, 32'd7);
    setv(19, 1'b0, 1'b1, 32'h100, 1'b0, 32'h42,  32'h100, 1'b1, 1'b1, 32'd7);
    setv(20, 1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 32'h104, 1'b0, 1'b0, 32'd7);
`else
    setv(17, 1'b0, 1'b1, 32'h42,  1'b0, 32'h0,   32'h40,  1'b0, 1'b0, 32'd7);
    setv(18, 1'b0, 1'b0, 32'h0,   1'b1, 32'h40,  32'h44,  1'b0, 1'b0, 32'd7);
    setv(19, 1'b0, 1'b1, 32'h100, 1'b0, 32'h44,  32'h100, 1'b0, 1'b0, 32'd8);
    setv(20, 1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 32'h104, 1'b0, 1'b0, 32'd8);
`endif

    // Outputs while reset is held.
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", {31'h0, if_valid}, 32'h0);
    chk("rst_halted", {31'h0, halted}, 32'h0);
    chk("rst_misalign", {31'h0, misalign}, 32'h0);
    chk("rst_count", fetch_count, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);

    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 21; i++) begin
      id_stall = vecs[i].stall;
      redirect_valid = vecs[i].redir;
      redirect_pc = vecs[i].rpc;
      #1;
      chk($sformatf("v%0d_valid", i), {31'h0, if_valid}, {31'h0, vecs[i].v});
      chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].addr);
      chk($sformatf("v%0d_halted", i), {31'h0, halted}, {31'h0, vecs[i].halt});
      chk($sformatf("v%0d_misalign", i), {31'h0, misalign}, {31'h0, vecs[i].mis});
      chk($sformatf("v%0d_count", i), fetch_count, vecs[i].cnt);
      if (vecs[i].v) begin
        chk($sformatf("v%0d_pc", i), if_pc, vecs[i].pc);
        chk($sformatf("v%0d_instr", i), if_instr, vecs[i].pc);
      end
      @(negedge clk);
    end

    // Reset in the middle of a cycle clears state at once.
    id_stall = 1'b0; redirect_valid = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_valid", {31'h0, if_valid}, 32'h0);
    chk("midrst_count", fetch_count, 32'h0);
    chk("midrst_addr", imem_addr, 32'h0);
    chk("midrst_halted", {31'h0, halted}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Randomized run against the reference model.
    for (int c = 0; c < 3000; c++) begin
      id_stall = ($urandom_range(3) == 0);
      redirect_valid = ($urandom_range(11) == 0);
      redirect_pc = {22'h0, 8'($urandom_range(255)), 2'b00};
      #1;
      w = mem_word(m_fly);
      e_valid = m_fly_ok && !m_halt && (w != EOF) && !redirect_valid;
      e_addr = redirect_valid ? redirect_pc : ((m_halt || id_stall) ? m_fly : m_next);
      chk("rnd_valid", {31'h0, if_valid}, {31'h0, e_valid});
      chk("rnd_addr", imem_addr, e_addr);
      chk("rnd_halted", {31'h0, halted}, {31'h0, m_halt});
      chk("rnd_misalign", {31'h0, misalign}, 32'h0);
      chk("rnd_count", fetch_count, m_cnt);
      if (e_valid) begin
        chk("rnd_pc", if_pc, m_fly);
        chk("rnd_instr", if_instr, w);
      end
      if (e_valid && !id_stall) m_cnt = m_cnt + 32'h1;
      if (redirect_valid) begin
        m_halt = 1'b0; m_fly = redirect_pc; m_fly_ok = 1'b1; m_next = redirect_pc + 32'h4;
      end else if (!m_halt && m_fly_ok && (w == EOF)) begin
        m_halt = 1'b1; m_fly_ok = 1'b0;
      end else if (!m_halt && !id_stall) begin
        m_fly = m_next; m_fly_ok = 1'b1; m_next = m_next + 32'h4;
      end
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
